// File: rtl/uart_fifo_tx_drain.sv
// uart_fifo_tx_drain
//   Read-side client of the multi-pop TX FIFO. Pops up to NO words at a time into
//   a local buffer and serialises each word as an 8N1-style UART frame on tx.
//   Frames run back-to-back while words keep arriving: the buffer is refilled
//   during the frame of its last word, so the next start bit follows the stop
//   bit directly.
//
// Parameters
//   W            data bits per frame / FIFO word width
//   NO           max words per pop (matches the FIFO)
//   CLKS_PER_BIT clk cycles per bit, >= 2
//   STOP_BITS    1 or 2
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   async reset, active low
//   tx_en     in   1: may pop and start frames; 0: finish current frame, then hold
//   can_pop   in   words available in the FIFO, 0..NO
//   pop_data  in   FIFO head words, pop_data[0] is the oldest
//   pop       out  words popped this cycle (combinational)
//   tx        out  serial line, idle high, registered
//   busy      out  frame in progress or buffered words pending
//
// Build option
//   UART_TX_PARITY_EN  adds an even-parity bit between DATA and STOP.
//
// state  | meaning
// IDLE   | line high, waiting for a buffered word and tx_en
// START  | start bit (low), one bit time
// DATA   | W data bits, LSB first
// PARITY | even parity bit (UART_TX_PARITY_EN builds only)
// STOP   | STOP_BITS stop bits (high); next word may load on the last cycle

module uart_fifo_tx_drain #(
  parameter int W            = 8,
  parameter int NO           = 2,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tx_en,
  input  logic [$clog2(NO+1)-1:0]    can_pop,
  input  logic [NO-1:0][W-1:0]       pop_data,
  output logic [$clog2(NO+1)-1:0]    pop,
  output logic                       tx,
  output logic                       busy
);

  localparam int CW  = $clog2(NO + 1);
  localparam int HW  = (NO > 1) ? $clog2(NO) : 1;
  localparam int BDW = $clog2(CLKS_PER_BIT);
  localparam int BTW = $clog2(W + 1);

  localparam logic [BDW-1:0] BAUD_TOP = BDW'(CLKS_PER_BIT - 1);
  localparam logic [BTW-1:0] DATA_TOP = BTW'(W - 1);
  localparam logic [BTW-1:0] STOP_TOP = BTW'(STOP_BITS - 1);
  localparam logic [CW-1:0]  NO_C     = CW'(NO);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif

  logic [2:0]     state;
  logic [W-1:0]   word_buf [NO];
  logic [CW-1:0]  buf_cnt;
  logic [HW-1:0]  head;
  logic [W-1:0]   shreg;
  logic [BDW-1:0] baud_cnt;
  logic [BTW-1:0] bit_cnt;
`ifdef UART_TX_PARITY_EN
  logic           par;
`endif

  logic baud_done, bit_done, load_ok, load_now;

  // Both timers count down; a bit (or the last bit of a field) ends at zero.
  assign baud_done = (baud_cnt == '0);
  assign bit_done  = (bit_cnt == '0);
  assign load_ok   = tx_en && (buf_cnt != '0);
  // A new word is only taken from idle or on the very last cycle of the frame.
  assign load_now  = load_ok &&
                     ((state == ST_IDLE) || (state == ST_STOP && baud_done && bit_done));

  // Refill only from an empty buffer; held at zero while reset is asserted so
  // the FIFO never loses a word into a buffer that is being cleared.
  always_comb begin
    pop = '0;
    if (rst_n && tx_en && (buf_cnt == '0))
      pop = (can_pop > NO_C) ? NO_C : can_pop;
  end

  assign busy = (state != ST_IDLE) || (buf_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      buf_cnt  <= '0;
      head     <= '0;
      shreg    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
      for (int i = 0; i < NO; i++) word_buf[i] <= '0;
    end else begin
      // pop and load are mutually exclusive: pop needs an empty buffer, load a non-empty one
      if (pop != '0) begin
        for (int i = 0; i < NO; i++)
          if (i < int'(pop)) word_buf[i] <= pop_data[i];
        buf_cnt <= pop;
        head    <= '0;
      end else if (load_now) begin
        shreg   <= word_buf[head];
        head    <= head + 1'b1;
        buf_cnt <= buf_cnt - 1'b1;
`ifdef UART_TX_PARITY_EN
        par     <= ^word_buf[head];
`endif
      end

      case (state)
        ST_IDLE: begin
          if (load_now) begin
            state    <= ST_START;
            baud_cnt <= BAUD_TOP;
            tx       <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_done) begin
            state    <= ST_DATA;
            baud_cnt <= BAUD_TOP;
            bit_cnt  <= DATA_TOP;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_cnt <= BAUD_TOP;
            if (bit_done) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
              tx    <= par;
`else
              state   <= ST_STOP;
              bit_cnt <= STOP_TOP;
              tx      <= 1'b1;
`endif
            end else begin
              // shreg[1] is the next bit out once the current one shifts away
              shreg   <= {1'b0, shreg[W-1:1]};
              tx      <= shreg[1];
              bit_cnt <= bit_cnt - 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_done) begin
            state    <= ST_STOP;
            baud_cnt <= BAUD_TOP;
            bit_cnt  <= STOP_TOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (baud_done) begin
            if (bit_done) begin
              if (load_ok) begin
                state    <= ST_START;
                baud_cnt <= BAUD_TOP;
                tx       <= 1'b0;
              end else begin
                state    <= ST_IDLE;
                baud_cnt <= '0;
                tx       <= 1'b1;
              end
            end else begin
              bit_cnt  <= bit_cnt - 1'b1;
              baud_cnt <= BAUD_TOP;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          baud_cnt <= '0;
          tx       <= 1'b1;
        end
      endcase
    end
  end

endmodule
